// File: rtl/ddls_start_sequencer.sv
// ddls_start_sequencer
// Drives the DDLS delayed-reset distributor through a fixed start order
// (assert resets, release core reset, release counter reset, run, drain),
// counts the enabled cycles and reports completion via busy/done. A start
// request with a non-one-hot delay select raises a sticky err and a done pulse
// without leaving IDLE.
module ddls_start_sequencer #(
  parameter int unsigned BUFFERSIZE = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SETTLE_W   = 8
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  start,
  input  logic                  stop,
  input  logic [BUFFERSIZE-1:0] cfg_delay_sel,
  input  logic [SETTLE_W-1:0]   cfg_settle,
  input  logic [CNT_W-1:0]      cfg_run_len,
  output logic                  core_resetb,
  output logic                  clk_cnt_resetb,
  output logic                  riscv_clk_en,
  output logic [BUFFERSIZE-1:0] delay_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      run_cnt
);

  // Two spare bits keep settle + BUFFERSIZE from wrapping.
  localparam int unsigned PH_W = SETTLE_W + 2;

  localparam logic [PH_W-1:0]       PH_ONE   = PH_W'(1);
  localparam logic [PH_W-1:0]       BUF_LEN  = PH_W'(BUFFERSIZE);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [BUFFERSIZE-1:0] SEL_ONE  = BUFFERSIZE'(1);

  typedef enum logic [2:0] {
    IDLE,
    ASSERT_RST,
    REL_RST,
    REL_CNT,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]      run_len_q, run_len_d;
  logic [CNT_W-1:0]      run_cnt_q, run_cnt_d;
  logic [BUFFERSIZE-1:0] delay_sel_q, delay_sel_d;
  logic                  core_resetb_q, core_resetb_d;
  logic                  clk_cnt_resetb_q, clk_cnt_resetb_d;
  logic                  riscv_clk_en_q, riscv_clk_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  cfg_onehot;
  logic [CNT_W-1:0]      run_cnt_inc;
  logic                  phase_end;

  // One-hot check: non-zero and clearing the lowest set bit leaves nothing.
  always_comb begin
    cfg_onehot = (cfg_delay_sel != '0) &&
                 ((cfg_delay_sel & (cfg_delay_sel - SEL_ONE)) == '0);
  end

  // Saturating run-cycle increment and end-of-phase detect.
  always_comb begin
    run_cnt_inc = (run_cnt_q == '1) ? run_cnt_q : (run_cnt_q + CNT_ONE);
    phase_end   = (phase_q == '0);
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q          <= IDLE;
      phase_q          <= '0;
      settle_q         <= '0;
      run_len_q        <= '0;
      run_cnt_q        <= '0;
      delay_sel_q      <= SEL_ONE;
      core_resetb_q    <= 1'b0;
      clk_cnt_resetb_q <= 1'b0;
      riscv_clk_en_q   <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      phase_q          <= phase_d;
      settle_q         <= settle_d;
      run_len_q        <= run_len_d;
      run_cnt_q        <= run_cnt_d;
      delay_sel_q      <= delay_sel_d;
      core_resetb_q    <= core_resetb_d;
      clk_cnt_resetb_q <= clk_cnt_resetb_d;
      riscv_clk_en_q   <= riscv_clk_en_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      err_q            <= err_d;
    end
  end

  // Next-state logic; each phase loads its length minus one into the phase
  // counter and the output levels for the next phase are set on the transition
  // so every output stays a plain register.
  always_comb begin
    state_d          = state_q;
    phase_d          = phase_q;
    settle_d         = settle_q;
    run_len_d        = run_len_q;
    run_cnt_d        = run_cnt_q;
    delay_sel_d      = delay_sel_q;
    core_resetb_d    = core_resetb_q;
    clk_cnt_resetb_d = clk_cnt_resetb_q;
    riscv_clk_en_d   = riscv_clk_en_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    err_d            = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (!cfg_onehot) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d          = ASSERT_RST;
            phase_d          = PH_W'(cfg_settle);
            settle_d         = cfg_settle;
            run_len_d        = cfg_run_len;
            delay_sel_d      = cfg_delay_sel;
            run_cnt_d        = '0;
            err_d            = 1'b0;
            busy_d           = 1'b1;
            core_resetb_d    = 1'b0;
            clk_cnt_resetb_d = 1'b0;
            riscv_clk_en_d   = 1'b0;
          end
        end
      end

      ASSERT_RST: begin
        if (phase_end) begin
          state_d       = REL_RST;
          phase_d       = PH_W'(settle_q) + BUF_LEN;
          core_resetb_d = 1'b1;
        end else begin
          phase_d = phase_q - PH_ONE;
        end
      end

      REL_RST: begin
        if (phase_end) begin
          state_d          = REL_CNT;
          phase_d          = BUF_LEN;
          clk_cnt_resetb_d = 1'b1;
        end else begin
          phase_d = phase_q - PH_ONE;
        end
      end

      REL_CNT: begin
        if (phase_end) begin
          state_d        = RUN;
          riscv_clk_en_d = 1'b1;
        end else begin
          phase_d = phase_q - PH_ONE;
        end
      end

      // stop and terminal count share one exit path, so coincidence is benign.
      RUN: begin
        run_cnt_d = run_cnt_inc;
        if (stop || ((run_len_q != '0) && (run_cnt_inc == run_len_q))) begin
          state_d        = DRAIN;
          phase_d        = BUF_LEN;
          riscv_clk_en_d = 1'b0;
        end
      end

      DRAIN: begin
        if (phase_end) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q - PH_ONE;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign core_resetb    = core_resetb_q;
  assign clk_cnt_resetb = clk_cnt_resetb_q;
  assign riscv_clk_en   = riscv_clk_en_q;
  assign delay_sel      = delay_sel_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign run_cnt        = run_cnt_q;

endmodule

// File: tb/tb_ddls_start_sequencer.sv
// Directed bench for ddls_start_sequencer (BUFFERSIZE=4, CNT_W=16, SETTLE_W=8).
module tb_ddls_start_sequencer;

  logic        clk;
  logic        resetb;
  logic        start;
  logic        stop;
  logic [3:0]  cfg_delay_sel;
  logic [7:0]  cfg_settle;
  logic [15:0] cfg_run_len;
  logic        core_resetb;
  logic        clk_cnt_resetb;
  logic        riscv_clk_en;
  logic [3:0]  delay_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] run_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  localparam int W_CRST = 0;
  localparam int W_CCRST = 1;
  localparam int W_EN = 2;
  localparam int W_DONE = 3;
  localparam int WAIT_LIMIT = 200;

  ddls_start_sequencer #(
    .BUFFERSIZE(4),
    .CNT_W(16),
    .SETTLE_W(8)
  ) dut (
    .clk(clk),
    .resetb(resetb),
    .start(start),
    .stop(stop),
    .cfg_delay_sel(cfg_delay_sel),
    .cfg_settle(cfg_settle),
    .cfg_run_len(cfg_run_len),
    .core_resetb(core_resetb),
    .clk_cnt_resetb(clk_cnt_resetb),
    .riscv_clk_en(riscv_clk_en),
    .delay_sel(delay_sel),
    .busy(busy),
    .done(done),
    .err(err),
    .run_cnt(run_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      W_CRST:  return core_resetb;
      W_CCRST: return clk_cnt_resetb;
      W_EN:    return riscv_clk_en;
      W_DONE:  return done;
      default: return busy;
    endcase
  endfunction

  // Counts edges until the selected output reaches v; capped at WAIT_LIMIT.
  task automatic wait_for(input int w, input logic v, output int cnt);
    cnt = 0;
    while (sig(w) !== v && cnt < WAIT_LIMIT) begin
      tick();
      cnt++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_resetb"}, core_resetb, 0);
    chk({tag, "_clk_cnt_resetb"}, clk_cnt_resetb, 0);
    chk({tag, "_en"}, riscv_clk_en, 0);
    chk({tag, "_delay_sel"}, delay_sel, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_run_cnt"}, run_cnt, 0);
  endtask

  initial begin
    resetb = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    cfg_delay_sel = 4'b0001;
    cfg_settle = 8'd0;
    cfg_run_len = 16'd0;
    #3 resetb = 1'b0;
    tick();
    tick();
    chk_reset_vals("rst");
    resetb = 1'b1;
    tick();

    // Nominal run: S=2, L=10, one-hot select 0100.
    cfg_delay_sel = 4'b0100;
    cfg_settle = 8'd2;
    cfg_run_len = 16'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_core_resetb", core_resetb, 0);
    chk("t1_delay_sel", delay_sel, 4'b0100);
    wait_for(W_CRST, 1'b1, n);
    chk("t1_assert_len", n, 3);
    wait_for(W_CCRST, 1'b1, n);
    chk("t1_relrst_len", n, 7);
    wait_for(W_EN, 1'b1, n);
    chk("t1_relcnt_len", n, 5);
    wait_for(W_EN, 1'b0, n);
    chk("t1_run_len", n, 10);
    chk("t1_run_cnt", run_cnt, 10);
    wait_for(W_DONE, 1'b1, n);
    chk("t1_drain_len", n, 5);
    chk("t1_busy_done", busy, 1);
    tick();
    chk("t1_done_width", done, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_core_resetb", core_resetb, 1);
    chk("t1_idle_clk_cnt_resetb", clk_cnt_resetb, 1);
    chk("t1_idle_run_cnt", run_cnt, 10);

    // Illegal selects: multi-bit then zero.
    cfg_delay_sel = 4'b0110;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_err", err, 1);
    chk("t2_done", done, 1);
    chk("t2_busy", busy, 0);
    chk("t2_core_resetb", core_resetb, 1);
    chk("t2_delay_sel", delay_sel, 4'b0100);
    chk("t2_run_cnt", run_cnt, 10);
    tick();
    chk("t2_done_drop", done, 0);
    chk("t2_err_sticky", err, 1);
    cfg_delay_sel = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2z_err", err, 1);
    chk("t2z_done", done, 1);
    chk("t2z_busy", busy, 0);
    tick();

    // L=0, stop on the 20th RUN cycle; the legal start clears err.
    cfg_delay_sel = 4'b0001;
    cfg_settle = 8'd2;
    cfg_run_len = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_err_clear", err, 0);
    chk("t3_core_resetb", core_resetb, 0);
    chk("t3_clk_cnt_resetb", clk_cnt_resetb, 0);
    chk("t3_run_cnt_clear", run_cnt, 0);
    wait_for(W_EN, 1'b1, n);
    chk("t3_to_run", n, 15);
    repeat (19) tick();
    chk("t3_en_19", riscv_clk_en, 1);
    chk("t3_cnt_19", run_cnt, 19);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3_en_fall", riscv_clk_en, 0);
    chk("t3_run_cnt", run_cnt, 20);
    wait_for(W_DONE, 1'b1, n);
    chk("t3_drain_len", n, 5);
    tick();

    // Asynchronous reset mid-RUN, then a normal run.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_for(W_EN, 1'b1, n);
    chk("t4_to_run", n, 15);
    repeat (3) tick();
    chk("t4_run_cnt_pre", run_cnt, 3);
    #2 resetb = 1'b0;
    #1;
    chk_reset_vals("t4_async");
    tick();
    resetb = 1'b1;
    tick();
    chk("t4_idle_busy", busy, 0);
    cfg_run_len = 16'd3;
    cfg_settle = 8'd0;
    cfg_delay_sel = 4'b1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_busy", busy, 1);
    wait_for(W_EN, 1'b1, n);
    chk("t4_to_run2", n, 11);
    wait_for(W_EN, 1'b0, n);
    chk("t4_run_len", n, 3);
    chk("t4_run_cnt", run_cnt, 3);
    wait_for(W_DONE, 1'b1, n);
    chk("t4_drain_len", n, 5);
    tick();

    // start held high through a whole run and the DONE cycle.
    cfg_run_len = 16'd2;
    start = 1'b1;
    tick();
    chk("t5_busy", busy, 1);
    chk("t5_core_resetb", core_resetb, 0);
    wait_for(W_DONE, 1'b1, n);
    chk("t5_to_done", n, 18);
    tick();
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_done", done, 0);
    chk("t5_idle_core_resetb", core_resetb, 1);
    tick();
    start = 1'b0;
    chk("t5_reaccept_busy", busy, 1);
    chk("t5_reaccept_core_resetb", core_resetb, 0);
    wait_for(W_DONE, 1'b1, n);
    chk("t5_to_done2", n, 18);
    tick();

    // L=1 with stop in the same cycle.
    cfg_run_len = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_for(W_EN, 1'b1, n);
    chk("t6_to_run", n, 11);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t6_en_fall", riscv_clk_en, 0);
    chk("t6_run_cnt", run_cnt, 1);
    wait_for(W_DONE, 1'b1, n);
    chk("t6_drain_len", n, 5);
    tick();
    chk("t6_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
